// File: rtl/reg_rename_file_pkg.sv
// rtl/reg_rename_file_pkg.sv - shared types and sizes for the rename register file
package reg_rename_file_pkg;

    localparam int REG_NUM   = 32;
    localparam int DATA_W    = 32;
    localparam int ROB_POS_W = 4;
    localparam int REG_POS_W = $clog2(REG_NUM);

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ROB_POS_W-1:0] rob_pos_t;
    typedef logic [REG_POS_W-1:0] reg_pos_t;

    // One source-operand answer as seen by the decoder
    typedef struct packed {
        logic     busy;
        data_t    val;
        rob_pos_t rob_pos;
    } query_t;

    // x0 is hardwired to zero and never renamed
    function automatic logic is_x0(input reg_pos_t r);
        return (r == '0);
    endfunction

endpackage

// File: rtl/reg_rename_file_if.sv
// rtl/reg_rename_file_if.sv - decoder/ROB side bundle of the rename register file
import reg_rename_file_pkg::*;

interface reg_rename_file_if;

    // Global control
    logic     rdy;
    logic     rollback;

    // Decoder issue
    logic     issue;
    reg_pos_t issue_rd;
    rob_pos_t issue_rob_pos;

    // ROB commit
    logic     reg_write;
    reg_pos_t reg_rd;
    data_t    reg_val;
    rob_pos_t commit_rob_pos;

    // Source operand queries
    reg_pos_t rs1_pos;
    logic     rs1_busy;
    data_t    rs1_val;
    rob_pos_t rs1_rob_pos;
    reg_pos_t rs2_pos;
    logic     rs2_busy;
    data_t    rs2_val;
    rob_pos_t rs2_rob_pos;

    // Decoder/ROB side drives requests and receives query answers
    modport master (
        output rdy, rollback,
        output issue, issue_rd, issue_rob_pos,
        output reg_write, reg_rd, reg_val, commit_rob_pos,
        output rs1_pos, rs2_pos,
        input  rs1_busy, rs1_val, rs1_rob_pos,
        input  rs2_busy, rs2_val, rs2_rob_pos
    );

    // Register file side
    modport slave (
        input  rdy, rollback,
        input  issue, issue_rd, issue_rob_pos,
        input  reg_write, reg_rd, reg_val, commit_rob_pos,
        input  rs1_pos, rs2_pos,
        output rs1_busy, rs1_val, rs1_rob_pos,
        output rs2_busy, rs2_val, rs2_rob_pos
    );

endinterface

// File: rtl/reg_rename_file_read_port.sv
// rtl/reg_rename_file_read_port.sv - one source-operand read mux; optional commit forwarding under REG_COMMIT_BYPASS_EN
import reg_rename_file_pkg::*;

module reg_rename_file_read_port (
    input  reg_pos_t                   rs_pos,
    input  data_t    [REG_NUM-1:0]     val_q,
    input  logic     [REG_NUM-1:0]     busy_q,
    input  rob_pos_t [REG_NUM-1:0]     tag_q,
`ifdef REG_COMMIT_BYPASS_EN
    input  logic                       commit_en,
    input  reg_pos_t                   reg_rd,
    input  data_t                      reg_val,
    input  rob_pos_t                   commit_rob_pos,
`endif
    output query_t                     q
);

    // Select the registered state; when forwarding is built in, a commit that
    // retires the current producer of this operand is returned in the same cycle
    always_comb begin
        q.busy    = busy_q[rs_pos];
        q.val     = val_q[rs_pos];
        q.rob_pos = tag_q[rs_pos];
`ifdef REG_COMMIT_BYPASS_EN
        if (commit_en && (reg_rd == rs_pos) && busy_q[rs_pos] &&
            (tag_q[rs_pos] == commit_rob_pos)) begin
            q.busy = 1'b0;
            q.val  = reg_val;
        end
`endif
    end

endmodule

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with rename tags; REG_COMMIT_BYPASS_EN enables commit forwarding
import reg_rename_file_pkg::*;

module reg_rename_file (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_rename_file_if.slave     rf
);

    data_t    [REG_NUM-1:0] val_q;
    logic     [REG_NUM-1:0] busy_q;
    rob_pos_t [REG_NUM-1:0] tag_q;

    logic   commit_en;
    logic   commit_clears;
    logic   issue_en;
    query_t rs1_q;
    query_t rs2_q;

    // x0 writes are dropped here so entry 0 keeps its reset value forever.
    // A commit only releases the register when it is still the newest producer.
    assign commit_en     = rf.reg_write && !is_x0(rf.reg_rd);
    assign commit_clears = commit_en && (tag_q[rf.reg_rd] == rf.commit_rob_pos);
    assign issue_en      = rf.issue && !is_x0(rf.issue_rd) && !rf.rollback;

    // Committed values land regardless of rollback (JALR link write rides with the flush)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
        end else if (rf.rdy && commit_en) begin
            val_q[rf.reg_rd] <= rf.reg_val;
        end
    end

    // Busy bits: rollback wipes all; otherwise issue overrides a same-register release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (rf.rdy) begin
            if (rf.rollback) begin
                busy_q <= '0;
            end else begin
                if (commit_clears) begin
                    busy_q[rf.reg_rd] <= 1'b0;
                end
                if (issue_en) begin
                    busy_q[rf.issue_rd] <= 1'b1;
                end
            end
        end
    end

    // Tags record the newest producer; they are left alone on rollback since busy is cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (rf.rdy && issue_en) begin
            tag_q[rf.issue_rd] <= rf.issue_rob_pos;
        end
    end

    reg_rename_file_read_port u_rs1 (
        .rs_pos         (rf.rs1_pos),
        .val_q          (val_q),
        .busy_q         (busy_q),
        .tag_q          (tag_q),
`ifdef REG_COMMIT_BYPASS_EN
        .commit_en      (commit_en),
        .reg_rd         (rf.reg_rd),
        .reg_val        (rf.reg_val),
        .commit_rob_pos (rf.commit_rob_pos),
`endif
        .q              (rs1_q)
    );

    reg_rename_file_read_port u_rs2 (
        .rs_pos         (rf.rs2_pos),
        .val_q          (val_q),
        .busy_q         (busy_q),
        .tag_q          (tag_q),
`ifdef REG_COMMIT_BYPASS_EN
        .commit_en      (commit_en),
        .reg_rd         (rf.reg_rd),
        .reg_val        (rf.reg_val),
        .commit_rob_pos (rf.commit_rob_pos),
`endif
        .q              (rs2_q)
    );

    assign rf.rs1_busy    = rs1_q.busy;
    assign rf.rs1_val     = rs1_q.val;
    assign rf.rs1_rob_pos = rs1_q.rob_pos;
    assign rf.rs2_busy    = rs2_q.busy;
    assign rf.rs2_val     = rs2_q.val;
    assign rf.rs2_rob_pos = rs2_q.rob_pos;

endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - directed scoreboard bench for reg_rename_file
import reg_rename_file_pkg::*;

module tb_reg_rename_file;

    logic clk;
    logic rst_n;

    reg_rename_file_if rif ();

    reg_rename_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string    tag;
        reg_pos_t pos;
        logic     busy;
        data_t    val;
        rob_pos_t rob;
        bit       chk_rob;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rif.issue          = 1'b0;
        rif.issue_rd       = '0;
        rif.issue_rob_pos  = '0;
        rif.reg_write      = 1'b0;
        rif.reg_rd         = '0;
        rif.reg_val        = '0;
        rif.commit_rob_pos = '0;
        rif.rollback       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic drv_issue(input reg_pos_t rd, input rob_pos_t pos);
        rif.issue         = 1'b1;
        rif.issue_rd      = rd;
        rif.issue_rob_pos = pos;
    endtask

    task automatic drv_commit(input reg_pos_t rd, input data_t v, input rob_pos_t pos);
        rif.reg_write      = 1'b1;
        rif.reg_rd         = rd;
        rif.reg_val        = v;
        rif.commit_rob_pos = pos;
    endtask

    // Push the expectation, present the query on both ports, then pop and compare
    task automatic query(input string tag, input reg_pos_t pos, input logic b,
                         input data_t v, input rob_pos_t r, input bit cr);
        exp_t e;
        sb.push_back('{tag, pos, b, v, r, cr});
        rif.rs1_pos = pos;
        rif.rs2_pos = pos;
        #1;
        e = sb.pop_front();
        chk({e.tag, ".rs1_busy"}, {31'd0, rif.rs1_busy}, {31'd0, e.busy});
        chk({e.tag, ".rs2_busy"}, {31'd0, rif.rs2_busy}, {31'd0, e.busy});
        if (!e.busy) begin
            chk({e.tag, ".rs1_val"}, rif.rs1_val, e.val);
            chk({e.tag, ".rs2_val"}, rif.rs2_val, e.val);
        end
        if (e.chk_rob) begin
            chk({e.tag, ".rs1_rob"}, {28'd0, rif.rs1_rob_pos}, {28'd0, e.rob});
            chk({e.tag, ".rs2_rob"}, {28'd0, rif.rs2_rob_pos}, {28'd0, e.rob});
        end
    endtask

    initial begin
        idle_inputs();
        rif.rdy     = 1'b1;
        rif.rs1_pos = '0;
        rif.rs2_pos = '0;
        rst_n       = 1'b0;
        #23;
        rst_n = 1'b1;

        // 1: reset state and x0 immunity
        query("rst_x5", 5'd5, 1'b0, 32'h0, 4'd0, 1'b1);
        query("rst_x31", 5'd31, 1'b0, 32'h0, 4'd0, 1'b1);
        @(posedge clk); #1;
        drv_issue(5'd0, 4'd3);
        step();
        query("x0_issue", 5'd0, 1'b0, 32'h0, 4'd0, 1'b0);
        drv_commit(5'd0, 32'hFFFF_FFFF, 4'd0);
        step();
        query("x0_commit", 5'd0, 1'b0, 32'h0, 4'd0, 1'b0);

        // 2: simple rename and release
        drv_issue(5'd5, 4'd2);
        step();
        query("x5_busy", 5'd5, 1'b1, 32'h0, 4'd2, 1'b1);
        drv_commit(5'd5, 32'hDEAD_BEEF, 4'd2);
        step();
        query("x5_done", 5'd5, 1'b0, 32'hDEAD_BEEF, 4'd0, 1'b0);

        // 3: older commit must not release a younger renamer
        drv_issue(5'd7, 4'd1);
        step();
        drv_issue(5'd7, 4'd4);
        step();
        drv_commit(5'd7, 32'h11, 4'd1);
        step();
        query("x7_old", 5'd7, 1'b1, 32'h0, 4'd4, 1'b1);
        rif.rs1_pos = 5'd7;
        #1;
        chk("x7_old.val", rif.rs1_val, 32'h11);
        drv_commit(5'd7, 32'h22, 4'd4);
        step();
        query("x7_new", 5'd7, 1'b0, 32'h22, 4'd0, 1'b0);

        // 4: same-cycle issue and commit on one register
        drv_issue(5'd9, 4'd6);
        drv_commit(5'd9, 32'h33, 4'd5);
        step();
        query("x9_same", 5'd9, 1'b1, 32'h0, 4'd6, 1'b1);
        rif.rs1_pos = 5'd9;
        #1;
        chk("x9_same.val", rif.rs1_val, 32'h33);
        // matching tag commit with a new issue: issue still wins
        drv_issue(5'd10, 4'd5);
        step();
        drv_issue(5'd10, 4'd7);
        drv_commit(5'd10, 32'h55, 4'd5);
        step();
        query("x10_race", 5'd10, 1'b1, 32'h0, 4'd7, 1'b1);

        // tag at the top of the range
        drv_issue(5'd12, 4'd15);
        step();
        query("x12_busy", 5'd12, 1'b1, 32'h0, 4'd15, 1'b1);
        drv_commit(5'd12, 32'hA5A5_0012, 4'd15);
        step();
        query("x12_done", 5'd12, 1'b0, 32'hA5A5_0012, 4'd0, 1'b0);

        // 5: rollback with JALR link commit and a suppressed issue
        drv_issue(5'd3, 4'd2);
        step();
        drv_issue(5'd4, 4'd3);
        step();
        query("x3_pre", 5'd3, 1'b1, 32'h0, 4'd2, 1'b1);
        rif.rollback = 1'b1;
        drv_commit(5'd1, 32'h8000_0004, 4'd8);
        drv_issue(5'd3, 4'd9);
        step();
        query("rb_x3", 5'd3, 1'b0, 32'h0, 4'd0, 1'b0);
        query("rb_x4", 5'd4, 1'b0, 32'h0, 4'd0, 1'b0);
        query("rb_x9", 5'd9, 1'b0, 32'h33, 4'd0, 1'b0);
        query("rb_x10", 5'd10, 1'b0, 32'h55, 4'd0, 1'b0);
        query("rb_x1", 5'd1, 1'b0, 32'h8000_0004, 4'd0, 1'b0);

        // 6: rdy low freezes all state
        rif.rdy = 1'b0;
        drv_issue(5'd6, 4'd5);
        step();
        drv_commit(5'd6, 32'h66, 4'd0);
        step();
        rif.rdy = 1'b1;
        query("rdy_x6", 5'd6, 1'b0, 32'h0, 4'd0, 1'b1);

        // same-cycle commit visibility on x5
        drv_issue(5'd5, 4'd11);
        step();
        drv_commit(5'd5, 32'h44, 4'd11);
`ifdef REG_COMMIT_BYPASS_EN
        query("byp_x5", 5'd5, 1'b0, 32'h44, 4'd0, 1'b0);
`else
        query("byp_x5", 5'd5, 1'b1, 32'h0, 4'd11, 1'b1);
`endif
        step();
        query("byp_x5_after", 5'd5, 1'b0, 32'h44, 4'd0, 1'b0);

        // asynchronous reset mid-stream, observed without a clock edge
        drv_issue(5'd20, 4'd1);
        step();
        query("x20_busy", 5'd20, 1'b1, 32'h0, 4'd1, 1'b1);
        rst_n = 1'b0;
        query("arst_x20", 5'd20, 1'b0, 32'h0, 4'd0, 1'b1);
        query("arst_x1", 5'd1, 1'b0, 32'h0, 4'd0, 1'b1);
        query("arst_x7", 5'd7, 1'b0, 32'h0, 4'd0, 1'b1);
        #3;
        rst_n = 1'b1;

        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Safety bound so the run can never hang
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
